if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: program counter and IF/ID pipeline register.
// Redirect beats stall; flush or redirect inserts a bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_pc_4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic        pc_redir, pc_hold, pc_inc;
    logic        id_bubble, id_hold, id_load;

    assign pc_plus4  = pc_q + 32'd4;

    assign pc_redir  = redirect;
    assign pc_hold   = stall & ~redirect;
    assign pc_inc    = ~stall & ~redirect;

    assign id_bubble = flush | redirect;
    assign id_hold   = stall & ~id_bubble;
    assign id_load   = ~stall & ~id_bubble;

    // Next PC: redirect target, hold, or sequential increment
    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            pc_redir: pc_d = {redirect_pc[31:2], 2'b00};
            pc_hold:  pc_d = pc_q;
            pc_inc:   pc_d = pc_plus4;
            default:  pc_d = pc_q;
        endcase
    end

    // Next IF/ID contents, sticky misalign flag and fetch counter
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q | (redirect & (|redirect_pc[1:0]));
        unique case (1'b1)
            id_bubble: begin
                inst_d  = NOP_INST;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end
            id_hold: begin
                inst_d  = inst_q;
                pc4_d   = pc4_q;
                valid_d = valid_q;
            end
            id_load: begin
                inst_d  = imem_data;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
            default: begin
                inst_d  = inst_q;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_inst   = inst_q;
    assign ifid_pc_4   = pc4_q;
    assign ifid_valid  = valid_q;
    assign misalign    = mis_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage.
// Directed scenarios followed by randomized control traffic.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_pc_4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid, m_mis;

    if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .ifid_pc_4(ifid_pc_4),
        .ifid_inst(ifid_inst),
        .ifid_valid(ifid_valid),
        .misalign(misalign),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    assign imem_data = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model predicts the
    // state visible after the coming rising edge.
    task automatic step(input logic r, input logic st,
                        input logic fl, input logic rd,
                        input logic [31:0] tgt);
        exp_t e;
        logic [31:0] fetched;
        @(negedge clk);
        rst = r;
        stall = st;
        flush = fl;
        redirect = rd;
        redirect_pc = tgt;
        if (!r) begin
            m_pc = RPC;
            m_inst = NOP;
            m_pc4 = 0;
            m_valid = 0;
            m_mis = 0;
            m_cnt = 0;
        end else begin
            fetched = rom(m_pc);
            if (fl || rd) begin
                m_inst = NOP;
                m_pc4 = 0;
                m_valid = 0;
            end else if (!st) begin
                m_inst = fetched;
                m_pc4 = m_pc + 4;
                m_valid = 1;
                m_cnt = m_cnt + 1;
            end
            if (rd && tgt[1:0] != 2'b00) m_mis = 1;
            if (rd) m_pc = tgt & 32'hFFFF_FFFC;
            else if (!st) m_pc = m_pc + 4;
        end
        e.pc = m_pc;
        e.inst = m_inst;
        e.pc4 = m_pc4;
        e.valid = m_valid;
        e.mis = m_mis;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT state to the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", imem_addr, e.pc);
                chk("sb_inst", ifid_inst, e.inst);
                chk("sb_pc4", ifid_pc_4, e.pc4);
                chk("sb_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
                chk("sb_mis", {31'b0, misalign}, {31'b0, e.mis});
                chk("sb_cnt", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        rst = 0;
        stall = 0;
        flush = 0;
        redirect = 0;
        redirect_pc = 0;
        m_pc = RPC;
        m_inst = NOP;
        m_pc4 = 0;
        m_valid = 0;
        m_mis = 0;
        m_cnt = 0;

        // Reset, with control inputs active to show they are ignored
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h80);
        settle();
        chk("rst_addr", imem_addr, RPC);
        chk("rst_inst", ifid_inst, NOP);
        chk("rst_valid", {31'b0, ifid_valid}, 0);
        chk("rst_cnt", fetch_count, 0);

        // Sequential run with a two-cycle stall on B
        step(1, 0, 0, 0, 0);
        settle();
        chk("seq_a", ifid_inst, rom(0));
        chk("seq_a_pc4", ifid_pc_4, 4);
        step(1, 0, 0, 0, 0);
        settle();
        chk("seq_b", ifid_inst, rom(4));
        chk("seq_b_addr", imem_addr, 8);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 0);
            settle();
            chk("stall_inst", ifid_inst, rom(4));
            chk("stall_addr", imem_addr, 8);
            chk("stall_cnt", fetch_count, 2);
        end
        step(1, 0, 0, 0, 0);
        settle();
        chk("seq_c", ifid_inst, rom(8));
        chk("seq_c_pc4", ifid_pc_4, 12);
        step(1, 0, 0, 0, 0);
        settle();
        chk("seq_d", ifid_inst, rom(12));
        chk("seq_d_pc4", ifid_pc_4, 16);
        chk("seq_cnt", fetch_count, 4);

        // Redirect wins over a simultaneous stall
        step(1, 1, 0, 1, 32'h40);
        settle();
        chk("rd_valid", {31'b0, ifid_valid}, 0);
        chk("rd_addr", imem_addr, 32'h40);
        step(1, 0, 0, 0, 0);
        settle();
        chk("rd_inst", ifid_inst, rom(32'h40));
        chk("rd_pc4", ifid_pc_4, 32'h44);

        // Flush during stall: bubble, PC holds
        step(1, 1, 1, 0, 0);
        settle();
        chk("fs_valid", {31'b0, ifid_valid}, 0);
        chk("fs_addr", imem_addr, 32'h44);

        // Misaligned redirect, then stickiness
        step(1, 0, 0, 1, 32'h42);
        settle();
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_set", {31'b0, misalign}, 1);
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 1, {$urandom_range(0, 255), 2'b00});
        settle();
        chk("mis_sticky", {31'b0, misalign}, 1);

        // PC wrap-around
        step(1, 0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        settle();
        chk("wrap_pc4", ifid_pc_4, 0);
        chk("wrap_inst", ifid_inst, rom(32'hFFFF_FFFC));
        step(1, 0, 0, 0, 0);
        settle();
        chk("wrap_addr", imem_addr, 4);

        // Mid-run reset with redirect active
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 32'h103);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        settle();
        chk("pre_cnt", fetch_count, 7);
        chk("pre_mis", {31'b0, misalign}, 1);
        step(0, 1, 1, 1, 32'h200);
        settle();
        chk("mrst_addr", imem_addr, RPC);
        chk("mrst_valid", {31'b0, ifid_valid}, 0);
        chk("mrst_cnt", fetch_count, 0);
        chk("mrst_mis", {31'b0, misalign}, 0);

        // Randomized control traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 31) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
